// File: rtl/range_scan_if.sv
// Channel-scan bus: scan control and packed levels in, committed classes and strobes out.
interface range_scan_if #(
    parameter int N   = 7,
    parameter int NCH = 4
);
    logic               ena;
    logic [NCH*N-1:0]   levels;
    logic [NCH*2-1:0]   class_out;
    logic               class_valid;
    logic [NCH-1:0]     change_pulse;
    logic               scan_done;

    modport master (
        output ena, levels,
        input  class_out, class_valid, change_pulse, scan_done
    );

    modport slave (
        input  ena, levels,
        output class_out, class_valid, change_pulse, scan_done
    );
endinterface

// File: rtl/range_scan_controller.sv
// Round-robin scanner sharing one range classifier across NCH channels, with per-channel
// debounce of the 2-bit class and registered change / scan-complete strobes.
module range_scan_controller #(
    parameter int N      = 7,
    parameter int NCH    = 4,
    parameter int STABLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    range_scan_if.slave  bus
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [IW-1:0] LAST     = IW'(NCH - 1);
    localparam logic [CW:0]   STABLE_W = (CW + 1)'(STABLE);

    typedef enum logic [1:0] {IDLE, SAMPLE, EVAL} state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [N-1:0]       sample_p0;
    logic [NCH*2-1:0]   class_q;
    logic [1:0]         cand_q [NCH];
    logic [CW-1:0]      cnt_q  [NCH];
    logic [NCH-1:0]     init_q;
    logic               class_valid_q;
    logic [NCH-1:0]     pulse_q;
    logic               scan_done_q;

    logic [1:0]         c_eval;
    logic [1:0]         cls_cur;
    logic [1:0]         cand_cur;
    logic [CW:0]        cnt_inc;

    // Top two level bits select the class: 11 -> high, 00 -> low, otherwise mid.
    function automatic logic [1:0] range_classifier(input logic [N-1:0] lvl);
        case (lvl[N-1 -: 2])
            2'b11:   return 2'b10;
            2'b00:   return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    // Stage p0: level of the current channel captured only in SAMPLE
    always_ff @(posedge clk) begin
        if (state == SAMPLE && bus.ena)
            sample_p0 <= bus.levels[idx*N +: N];
    end

    assign c_eval   = range_classifier(sample_p0);
    assign cls_cur  = class_q[idx*2 +: 2];
    assign cand_cur = cand_q[idx];
    assign cnt_inc  = {1'b0, cnt_q[idx]} + (CW + 1)'(1);

    // Stage p1: classify, debounce and commit for channel idx
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
            pulse_q       <= '0;
            scan_done_q   <= 1'b0;
            init_q        <= '0;
            for (int k = 0; k < NCH; k++) begin
                cand_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            pulse_q     <= '0;
            scan_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ena)
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    state <= bus.ena ? EVAL : IDLE;
                end
                EVAL: begin
                    if (!init_q[idx]) begin
                        class_q[idx*2 +: 2] <= c_eval;
                        init_q[idx]         <= 1'b1;
                        cnt_q[idx]          <= '0;
                        cand_q[idx]         <= c_eval;
                    end else if (c_eval == cls_cur) begin
                        cnt_q[idx]  <= '0;
                        cand_q[idx] <= cls_cur;
                    end else if (c_eval != cand_cur) begin
                        cand_q[idx] <= c_eval;
                        if (STABLE == 1) begin
                            class_q[idx*2 +: 2] <= c_eval;
                            cnt_q[idx]          <= '0;
                            pulse_q[idx]        <= 1'b1;
                        end else begin
                            cnt_q[idx] <= CW'(1);
                        end
                    end else if (cnt_inc == STABLE_W) begin
                        class_q[idx*2 +: 2] <= cand_cur;
                        cnt_q[idx]          <= '0;
                        pulse_q[idx]        <= 1'b1;
                    end else begin
                        cnt_q[idx] <= cnt_inc[CW-1:0];
                    end

                    if (idx == LAST) begin
                        idx           <= '0;
                        scan_done_q   <= 1'b1;
                        class_valid_q <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                    state <= bus.ena ? SAMPLE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.class_out    = class_q;
    assign bus.class_valid  = class_valid_q;
    assign bus.change_pulse = pulse_q;
    assign bus.scan_done    = scan_done_q;

endmodule

// File: tb/tb_range_scan_controller.sv
// Scoreboard bench for range_scan_controller: a per-scan debounce model predicts committed
// classes and change pulses; predictions are queued at stimulus time and retired on scan_done.
module tb_range_scan_controller;

    localparam int N      = 7;
    localparam int NCH    = 4;
    localparam int STABLE = 2;

    typedef struct packed {
        logic [NCH*2-1:0] cls;
        logic [NCH-1:0]   pulse;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    range_scan_if #(.N(N), .NCH(NCH)) bus ();

    range_scan_controller #(.N(N), .NCH(NCH), .STABLE(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    logic [1:0] m_cls  [NCH];
    logic [1:0] m_cand [NCH];
    int         m_cnt  [NCH];
    bit         m_init [NCH];
    bit         m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*N-1:0] lv4(input logic [6:0] c0, input logic [6:0] c1,
                                             input logic [6:0] c2, input logic [6:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [1:0] model_class(input logic [N-1:0] lvl);
        logic [1:0] top;
        top = lvl[N-1 -: 2];
        if (top == 2'b11) return 2'b10;
        if (top == 2'b00) return 2'b00;
        return 2'b01;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_cls[k] = 2'b00; m_cand[k] = 2'b00; m_cnt[k] = 0; m_init[k] = 1'b0;
        end
        m_valid = 1'b0;
    endtask

    // One full scan of the model with levels held constant for the scan.
    task automatic model_scan(input logic [NCH*N-1:0] lv, output exp_t e);
        logic [1:0] c;
        e = '0;
        for (int k = 0; k < NCH; k++) begin
            c = model_class(lv[k*N +: N]);
            if (!m_init[k]) begin
                m_init[k] = 1'b1; m_cls[k] = c; m_cand[k] = c; m_cnt[k] = 0;
            end else if (c == m_cls[k]) begin
                m_cand[k] = c; m_cnt[k] = 0;
            end else begin
                if (c == m_cand[k]) m_cnt[k] = m_cnt[k] + 1;
                else begin m_cand[k] = c; m_cnt[k] = 1; end
                if (m_cnt[k] >= STABLE) begin
                    m_cls[k] = c; m_cnt[k] = 0; e.pulse[k] = 1'b1;
                end
            end
            e.cls[k*2 +: 2] = m_cls[k];
        end
        m_valid = 1'b1;
    endtask

    task automatic retire(input string tag, input int pulse_cycles, input logic [NCH-1:0] pulse_or);
        exp_t e;
        e = sb_q.pop_front();
        chk({tag, "_class_out"}, 32'(bus.class_out), 32'(e.cls));
        chk({tag, "_pulses"}, 32'(pulse_or), 32'(e.pulse));
        chk({tag, "_pulse_cycles"}, 32'(pulse_cycles), 32'($countones(e.pulse)));
        chk({tag, "_pulse_at_done"}, 32'(bus.change_pulse), 32'({e.pulse[NCH-1], {(NCH-1){1'b0}}}));
        chk({tag, "_valid"}, 32'(bus.class_valid), 32'd1);
    endtask

    task automatic run_scan(input logic [NCH*N-1:0] lv, input string tag);
        exp_t            e;
        int              pc;
        logic [NCH-1:0]  por;
        bit              got;
        bit              vprev;
        bus.levels = lv;
        vprev = m_valid;
        model_scan(lv, e);
        sb_q.push_back(e);
        pc = 0; por = '0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            pc  += $countones(bus.change_pulse);
            por |= bus.change_pulse;
            if (bus.scan_done) got = 1'b1;
            else chk({tag, "_valid_mid"}, 32'(bus.class_valid), 32'(vprev));
        end
        if (!got) begin
            void'(sb_q.pop_front());
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        retire(tag, pc, por);
    endtask

    logic [NCH*N-1:0] lv;
    logic [NCH*2-1:0] held_cls;
    exp_t             e_p;
    int               pc_p;
    logic [NCH-1:0]   por_p;
    int               lat;
    bit               done_p;

    initial begin
        rst_n      = 1'b0;
        bus.ena    = 1'b0;
        bus.levels = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_class_out", 32'(bus.class_out), 32'd0);
        chk("rst_valid", 32'(bus.class_valid), 32'd0);
        chk("rst_pulse", 32'(bus.change_pulse), 32'd0);
        chk("rst_done", 32'(bus.scan_done), 32'd0);
        rst_n   = 1'b1;
        bus.ena = 1'b1;

        lv = lv4(7'h10, 7'h70, 7'h40, 7'h10);
        run_scan(lv, "init_scan");

        lv = lv4(7'h60, 7'h70, 7'h40, 7'h10);
        run_scan(lv, "ch0_hi_1");
        run_scan(lv, "ch0_hi_2");

        lv = lv4(7'h10, 7'h70, 7'h40, 7'h10);
        run_scan(lv, "ch0_lo_1");
        run_scan(lv, "ch0_lo_2");

        run_scan(lv4(7'h60, 7'h70, 7'h40, 7'h10), "glitch");
        run_scan(lv, "glitch_back_1");
        run_scan(lv, "glitch_back_2");

        run_scan(lv4(7'h10, 7'h70, 7'h40, 7'h40), "alt_1");
        run_scan(lv4(7'h10, 7'h70, 7'h40, 7'h70), "alt_2");
        run_scan(lv4(7'h10, 7'h70, 7'h40, 7'h40), "alt_3");
        run_scan(lv4(7'h10, 7'h70, 7'h40, 7'h70), "alt_4");
        lv = lv4(7'h10, 7'h70, 7'h40, 7'h70);
        run_scan(lv, "ch3_commit");
        run_scan(lv, "ch3_hold");

        // Pause in SAMPLE of ch2: four edges after scan_done the FSM sits there.
        bus.levels = lv;
        model_scan(lv, e_p);
        sb_q.push_back(e_p);
        pc_p = 0; por_p = '0;
        repeat (4) begin
            @(negedge clk);
            pc_p  += $countones(bus.change_pulse);
            por_p |= bus.change_pulse;
        end
        bus.ena  = 1'b0;
        held_cls = bus.class_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("pause_done", 32'(bus.scan_done), 32'd0);
            chk("pause_class", 32'(bus.class_out), 32'(held_cls));
        end
        bus.ena = 1'b1;
        lat = 0; done_p = 1'b0;
        for (int i = 0; i < 20 && !done_p; i++) begin
            @(negedge clk);
            lat++;
            pc_p  += $countones(bus.change_pulse);
            por_p |= bus.change_pulse;
            if (bus.scan_done) done_p = 1'b1;
        end
        // IDLE->SAMPLE, then sample/eval of ch2 and ch3: five edges.
        chk("pause_resume_latency", 32'(lat), 32'd5);
        if (done_p) retire("pause", pc_p, por_p);
        else begin
            void'(sb_q.pop_front());
            chk("pause_timeout", 32'd0, 32'd1);
        end

        // Async reset while in EVAL of ch0 with non-zero committed classes.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_class_out", 32'(bus.class_out), 32'd0);
        chk("arst_valid", 32'(bus.class_valid), 32'd0);
        chk("arst_pulse", 32'(bus.change_pulse), 32'd0);
        chk("arst_done", 32'(bus.scan_done), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(lv, "reinit_scan");
        run_scan(lv4(7'h60, 7'h10, 7'h40, 7'h70), "post_rst_1");
        run_scan(lv4(7'h60, 7'h10, 7'h40, 7'h70), "post_rst_2");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=%0d", 1, 0);
        $fatal(1, "time limit");
    end

endmodule
